// File: rtl/priority_resolver_control_pkg.sv
// Shared definitions for the 8259A-style priority resolver.
// Contents:
//   state_e        - acknowledge sequencer states
//   NUM_IR         - number of interrupt lines
//   SPURIOUS_LEVEL - level reported when INTA finds no valid request
//   rotate_level() - priority rank of a level (0 = highest) for a given
//                    lowest-priority pointer
package pic_pkg;

  localparam int          NUM_IR         = 8;
  localparam logic [2:0]  SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_e;

  // The level just after the lowest-priority one ranks 0. Modulo-8
  // wrap comes for free from 3-bit arithmetic.
  function automatic logic [2:0] rotate_level(input logic [2:0] level,
                                              input logic [2:0] lowest);
    return level - lowest - 3'd1;
  endfunction

endpackage

// File: rtl/priority_resolver_control_if.sv
// Bus bundle between the request register / control logic (master) and
// the priority resolver (slave).
// Master drives: interrupt_req_reg, interrupt_mask, inta, eoi_cmd,
//   eoi_specific, eoi_level, rotate_on_eoi, auto_eoi, vector_base.
// Slave drives: int_out, freeze, clear_ir_line, in_service_reg,
//   vector_out, vector_valid.
interface priority_resolver_control_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0] interrupt_req_reg;
  logic [NUM_IR-1:0] interrupt_mask;
  logic              inta;
  logic              eoi_cmd;
  logic              eoi_specific;
  logic [2:0]        eoi_level;
  logic              rotate_on_eoi;
  logic              auto_eoi;
  logic [4:0]        vector_base;
  logic              int_out;
  logic              freeze;
  logic [NUM_IR-1:0] clear_ir_line;
  logic [NUM_IR-1:0] in_service_reg;
  logic [7:0]        vector_out;
  logic              vector_valid;

  modport master (
    output interrupt_req_reg, interrupt_mask, inta, eoi_cmd, eoi_specific,
           eoi_level, rotate_on_eoi, auto_eoi, vector_base,
    input  int_out, freeze, clear_ir_line, in_service_reg, vector_out,
           vector_valid
  );

  modport slave (
    input  interrupt_req_reg, interrupt_mask, inta, eoi_cmd, eoi_specific,
           eoi_level, rotate_on_eoi, auto_eoi, vector_base,
    output int_out, freeze, clear_ir_line, in_service_reg, vector_out,
           vector_valid
  );
endinterface

// File: rtl/priority_resolver_control_rotating_priority_encoder.sv
// Combinational find-first-set in rotated priority order.
// Ports:
//   req             - request vector (bit n = level n)
//   lowest_priority - level with the lowest priority; lowest+1 is highest
//   level           - highest-priority set level (0 when none)
//   valid           - at least one bit of req is set
module rotating_priority_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  logic [2:0]        lowest_priority,
  output logic [2:0]        level,
  output logic              valid
);

  logic [2:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    level = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      idx = lowest_priority + 3'd1 + 3'(i);
      if (req[idx]) begin
        level = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_resolver_control.sv
// Priority resolver and acknowledge sequencer of an 8259A-style PIC
// (8086 mode). Masks pending requests, resolves them against the in-service
// register with fully nested priority, raises INT, runs the two-pulse INTA
// sequence and handles EOI / auto-EOI with optional priority rotation.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of priority_resolver_control_if
module priority_resolver_control
  import pic_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  priority_resolver_control_if.slave         bus
);

  state_e            state_q, state_d;
  logic [2:0]        level_q, level_d;
  logic              spurious_q, spurious_d;
  logic [2:0]        lowest_q, lowest_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic              int_out_q, int_out_d;
  logic              freeze_q, freeze_d;
  logic [NUM_IR-1:0] clear_q, clear_d;
  logic [7:0]        vector_q, vector_d;
  logic              vector_valid_q, vector_valid_d;

  logic [NUM_IR-1:0] candidates;
  logic [2:0]        cand_level, isr_level;
  logic              cand_valid, isr_valid, winner_valid;
  logic [NUM_IR-1:0] isr_set, aeoi_clr, eoi_clr;
  logic              eoi_named;
  logic [2:0]        eoi_lvl;

  assign candidates = bus.interrupt_req_reg & ~bus.interrupt_mask;

  rotating_priority_encoder u_cand_enc (
    .req             (candidates),
    .lowest_priority (lowest_q),
    .level           (cand_level),
    .valid           (cand_valid)
  );

  rotating_priority_encoder u_isr_enc (
    .req             (isr_q),
    .lowest_priority (lowest_q),
    .level           (isr_level),
    .valid           (isr_valid)
  );

  // Fully nested: a request must outrank every level already in service.
  assign winner_valid = cand_valid &&
    (!isr_valid || (rotate_level(cand_level, lowest_q) <
                    rotate_level(isr_level, lowest_q)));

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    spurious_d     = spurious_q;
    lowest_d       = lowest_q;
    int_out_d      = 1'b0;
    freeze_d       = freeze_q;
    clear_d        = '0;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    isr_set        = '0;
    aeoi_clr       = '0;
    eoi_clr        = '0;
    eoi_named      = 1'b0;
    eoi_lvl        = '0;

    unique case (state_q)
      IDLE: begin
        int_out_d = winner_valid;
        if (bus.inta) begin
          state_d   = ACK1;
          freeze_d  = 1'b1;
          int_out_d = 1'b0;
          if (winner_valid) begin
            level_d    = cand_level;
            spurious_d = 1'b0;
            isr_set    = 8'b1 << cand_level;
            clear_d    = 8'b1 << cand_level;
          end else begin
            level_d    = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (bus.inta) begin
          state_d        = ACK2;
          vector_d       = {bus.vector_base, level_q};
          vector_valid_d = 1'b1;
          freeze_d       = 1'b0;
          if (bus.auto_eoi && !spurious_q) begin
            aeoi_clr = 8'b1 << level_q;
            if (bus.rotate_on_eoi) lowest_d = level_q;
          end
        end
      end
      ACK2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // EOI looks at the pre-cycle ISR; an explicit EOI rotation overrides
    // an auto-EOI rotation in the same cycle.
    if (bus.eoi_cmd) begin
      if (bus.eoi_specific) begin
        eoi_clr   = 8'b1 << bus.eoi_level;
        eoi_named = 1'b1;
        eoi_lvl   = bus.eoi_level;
      end else if (isr_valid) begin
        eoi_clr   = 8'b1 << isr_level;
        eoi_named = 1'b1;
        eoi_lvl   = isr_level;
      end
      if (eoi_named && bus.rotate_on_eoi) lowest_d = eoi_lvl;
    end

    // A set on the same bit as a clear wins.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q        <= IDLE;
      level_q        <= '0;
      spurious_q     <= 1'b0;
      lowest_q       <= 3'd7;
      isr_q          <= '0;
      int_out_q      <= 1'b0;
      freeze_q       <= 1'b0;
      clear_q        <= '0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      spurious_q     <= spurious_d;
      lowest_q       <= lowest_d;
      isr_q          <= isr_d;
      int_out_q      <= int_out_d;
      freeze_q       <= freeze_d;
      clear_q        <= clear_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign bus.int_out        = int_out_q;
  assign bus.freeze         = freeze_q;
  assign bus.clear_ir_line  = clear_q;
  assign bus.in_service_reg = isr_q;
  assign bus.vector_out     = vector_q;
  assign bus.vector_valid   = vector_valid_q;

endmodule
